// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the two-port data-memory arbiter: FSM encoding,
// requester ids and the wait-counter width.
package dmem_arb_pkg;

  localparam int unsigned LAT_W = 4;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// Combinational two-way round-robin picker: a lone requester wins, a
// simultaneous pair goes to the port that did not win last time.
module rr_arbiter2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] grant,
  output logic       grant_id
);

  always_comb begin
    grant    = '0;
    grant_id = PORT_CPU;
    case (req)
      2'b01:   grant_id = PORT_CPU;
      2'b10:   grant_id = PORT_DMA;
      2'b11:   grant_id = ~last_grant;
      default: grant_id = PORT_CPU;
    endcase
    if (enable && (|req)) grant[grant_id] = 1'b1;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between CPU (port 0) and DMA (port 1), one
// word at a time. Define DMEM_ARB_ALIGN_CHK_EN to reject misaligned accesses.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ready,
  output logic              m0_done,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ready,
  output logic              m1_done,
  output logic [DATA_W-1:0] m1_rdata,
`ifdef DMEM_ARB_ALIGN_CHK_EN
  output logic              m0_err,
  output logic              m1_err,
`endif
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [LAT_W-1:0]    cnt_q, cnt_d;
  logic                last_grant_q, last_grant_d;
  logic                m0_done_q, m0_done_d;
  logic                m1_done_q, m1_done_d;
  logic [DATA_W-1:0]   m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0]   m1_rdata_q, m1_rdata_d;

  logic [1:0]          grant;
  logic                grant_id;
  logic                accept;
  logic                finish;
  logic                xfer_bad;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  rr_arbiter2 u_rr (
    .req        ({m1_req, m0_req}),
    .last_grant (last_grant_q),
    .enable     (state_q == ST_IDLE),
    .grant      (grant),
    .grant_id   (grant_id)
  );

  assign accept    = |grant;
  assign sel_we    = grant_id ? m1_we    : m0_we;
  assign sel_addr  = grant_id ? m1_addr  : m0_addr;
  assign sel_wdata = grant_id ? m1_wdata : m0_wdata;

`ifdef DMEM_ARB_ALIGN_CHK_EN
  // Misaligned transactions are flagged at accept and never strobe memory.
  logic bad_q, bad_d;
  logic m0_err_q, m0_err_d;
  logic m1_err_q, m1_err_d;

  assign xfer_bad = bad_q;
  assign m0_err   = m0_err_q;
  assign m1_err   = m1_err_q;

  always_comb begin
    bad_d    = bad_q;
    m0_err_d = 1'b0;
    m1_err_d = 1'b0;
    if (accept) bad_d = (sel_addr[1:0] != 2'b00);
    if (finish && bad_q) begin
      m0_err_d = (owner_q == PORT_CPU);
      m1_err_d = (owner_q == PORT_DMA);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bad_q    <= 1'b0;
      m0_err_q <= 1'b0;
      m1_err_q <= 1'b0;
    end else begin
      bad_q    <= bad_d;
      m0_err_q <= m0_err_d;
      m1_err_q <= m1_err_d;
    end
  end
`else
  assign xfer_bad = 1'b0;
`endif

  // Writes and rejected accesses take one ACCESS cycle; reads run until the counter drains.
  assign finish = (state_q == ST_ACCESS) && (we_q || xfer_bad || (cnt_q == '0));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= PORT_CPU;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      last_grant_q <= PORT_DMA;
      m0_done_q    <= 1'b0;
      m1_done_q    <= 1'b0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      m0_done_q    <= m0_done_d;
      m1_done_q    <= m1_done_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_ACCESS;
      ST_ACCESS: if (finish) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wd    = '0;
    m0_ready  = grant[PORT_CPU];
    m1_ready  = grant[PORT_DMA];
    if (state_q == ST_ACCESS) begin
      mem_addr = addr_q;
      if (!xfer_bad) begin
        mem_write = we_q;
        mem_read  = !we_q;
        if (we_q) mem_wd = wdata_q;
      end
    end
  end

  // Transaction latch, wait counter and completion/read-data capture.
  always_comb begin
    owner_d      = owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    m0_done_d    = 1'b0;
    m1_done_d    = 1'b0;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;
    if (accept) begin
      owner_d      = grant_id;
      we_d         = sel_we;
      addr_d       = sel_addr;
      wdata_d      = sel_wdata;
      cnt_d        = LAT_W'(MEM_LAT);
      last_grant_d = grant_id;
    end else if (finish) begin
      m0_done_d = (owner_q == PORT_CPU);
      m1_done_d = (owner_q == PORT_DMA);
      if (!we_q && !xfer_bad) begin
        if (owner_q == PORT_CPU) m0_rdata_d = mem_rd;
        else                     m1_rdata_d = mem_rd;
      end
    end else if (state_q == ST_ACCESS) begin
      cnt_d = cnt_q - LAT_W'(1);
    end
  end

  assign m0_done  = m0_done_q;
  assign m1_done  = m1_done_q;
  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: three instances with MEM_LAT 1, 3 and 0,
// each backed by a small word-addressed memory model.
module tb_dmem_arbiter;

  localparam int unsigned NI = 3;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst       [NI];
  logic          m0_req    [NI];
  logic          m0_we     [NI];
  logic [AW-1:0] m0_addr   [NI];
  logic [DW-1:0] m0_wdata  [NI];
  logic          m0_ready  [NI];
  logic          m0_done   [NI];
  logic [DW-1:0] m0_rdata  [NI];
  logic          m1_req    [NI];
  logic          m1_we     [NI];
  logic [AW-1:0] m1_addr   [NI];
  logic [DW-1:0] m1_wdata  [NI];
  logic          m1_ready  [NI];
  logic          m1_done   [NI];
  logic [DW-1:0] m1_rdata  [NI];
  logic          mem_read  [NI];
  logic          mem_write [NI];
  logic [AW-1:0] mem_addr  [NI];
  logic [DW-1:0] mem_wd    [NI];
  logic [DW-1:0] mem_rd    [NI];
`ifdef DMEM_ARB_ALIGN_CHK_EN
  logic          m0_err    [NI];
  logic          m1_err    [NI];
`endif

  logic          bd_en;
  logic [5:0]    bd_idx;
  logic [DW-1:0] bd_val;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 0);
    logic [DW-1:0] mem_arr [64];

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) u_dut (
      .clk       (clk),
      .rst       (rst[g]),
      .m0_req    (m0_req[g]),
      .m0_we     (m0_we[g]),
      .m0_addr   (m0_addr[g]),
      .m0_wdata  (m0_wdata[g]),
      .m0_ready  (m0_ready[g]),
      .m0_done   (m0_done[g]),
      .m0_rdata  (m0_rdata[g]),
      .m1_req    (m1_req[g]),
      .m1_we     (m1_we[g]),
      .m1_addr   (m1_addr[g]),
      .m1_wdata  (m1_wdata[g]),
      .m1_ready  (m1_ready[g]),
      .m1_done   (m1_done[g]),
      .m1_rdata  (m1_rdata[g]),
`ifdef DMEM_ARB_ALIGN_CHK_EN
      .m0_err    (m0_err[g]),
      .m1_err    (m1_err[g]),
`endif
      .mem_read  (mem_read[g]),
      .mem_write (mem_write[g]),
      .mem_addr  (mem_addr[g]),
      .mem_wd    (mem_wd[g]),
      .mem_rd    (mem_rd[g])
    );

    always @(posedge clk) begin
      if (bd_en) mem_arr[bd_idx] <= bd_val;
      if (mem_write[g]) mem_arr[mem_addr[g][7:2]] <= mem_wd[g];
    end
    assign mem_rd[g] = mem_arr[mem_addr[g][7:2]];
  end

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ports(input int g);
    m0_req[g] = 1'b0; m0_we[g] = 1'b0; m0_addr[g] = '0; m0_wdata[g] = '0;
    m1_req[g] = 1'b0; m1_we[g] = 1'b0; m1_addr[g] = '0; m1_wdata[g] = '0;
  endtask

  task automatic pulse_rst(input int g);
    rst[g] = 1'b0;
    next_cyc();
    rst[g] = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic seen;
    bd_en = 1'b0; bd_idx = '0; bd_val = '0;
    for (int i = 0; i < NI; i++) begin
      rst[i] = 1'b0;
      idle_ports(i);
    end

    // Preload 0x10, 0x14, 0x18 while all instances are held in reset.
    next_cyc(); bd_en = 1'b1; bd_idx = 6'd4; bd_val = 32'hDEADBEEF;
    next_cyc(); bd_idx = 6'd5; bd_val = 32'hCAFEF00D;
    next_cyc(); bd_idx = 6'd6; bd_val = 32'h0BADF00D;
    next_cyc(); bd_en = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      check_eq("rst m0_done", m0_done[i], 0);
      check_eq("rst m1_done", m1_done[i], 0);
      check_eq("rst m0_rdata", m0_rdata[i], 0);
      check_eq("rst mem_read", mem_read[i], 0);
      rst[i] = 1'b1;
    end

    // Single read, MEM_LAT=1.
    next_cyc(); m0_req[0] = 1'b1; m0_addr[0] = 32'h10; #1;
    check_eq("rd c0 m0_ready", m0_ready[0], 1);
    check_eq("rd c0 mem_read", mem_read[0], 0);
    next_cyc(); m0_req[0] = 1'b0; #1;
    check_eq("rd c1 mem_read", mem_read[0], 1);
    check_eq("rd c1 mem_addr", mem_addr[0], 32'h10);
    check_eq("rd c1 m0_ready", m0_ready[0], 0);
    next_cyc(); #1;
    check_eq("rd c2 mem_read", mem_read[0], 1);
    check_eq("rd c2 m0_done", m0_done[0], 0);
    next_cyc(); #1;
    check_eq("rd c3 m0_done", m0_done[0], 1);
    check_eq("rd c3 m0_rdata", m0_rdata[0], 32'hDEADBEEF);
    check_eq("rd c3 mem_read", mem_read[0], 0);
    check_eq("rd c3 m1_done", m1_done[0], 0);
    next_cyc(); #1;
    check_eq("rd c4 m0_done", m0_done[0], 0);
    check_eq("rd c4 m0_rdata", m0_rdata[0], 32'hDEADBEEF);

    // Simultaneous requests after reset: m0, m1, then m0, m1 again.
    pulse_rst(0);
    for (int rep = 0; rep < 2; rep++) begin
      next_cyc();
      m0_req[0] = 1'b1; m0_addr[0] = 32'h10;
      m1_req[0] = 1'b1; m1_addr[0] = 32'h14; #1;
      if (rep == 1) begin
        check_eq("rr m1_done", m1_done[0], 1);
        check_eq("rr m1_rdata", m1_rdata[0], 32'hCAFEF00D);
      end
      check_eq("rr pair m0_ready", m0_ready[0], 1);
      check_eq("rr pair m1_ready", m1_ready[0], 0);
      next_cyc(); m0_req[0] = 1'b0; #1;
      check_eq("rr wait m1_ready", m1_ready[0], 0);
      next_cyc(); #1;
      next_cyc(); #1;
      check_eq("rr m0_done", m0_done[0], 1);
      check_eq("rr m1_ready", m1_ready[0], 1);
      check_eq("rr m0_ready", m0_ready[0], 0);
      next_cyc(); m1_req[0] = 1'b0; #1;
      check_eq("rr m1 mem_addr", mem_addr[0], 32'h14);
      next_cyc(); #1;
    end
    next_cyc(); #1;
    check_eq("rr last m1_done", m1_done[0], 1);
    check_eq("rr last m1_rdata", m1_rdata[0], 32'hCAFEF00D);

    // m1 write then m0 read-back of the same word.
    next_cyc();
    m1_req[0] = 1'b1; m1_we[0] = 1'b1; m1_addr[0] = 32'h20; m1_wdata[0] = 32'h12345678; #1;
    check_eq("wr c0 m1_ready", m1_ready[0], 1);
    check_eq("wr c0 mem_write", mem_write[0], 0);
    next_cyc(); idle_ports(0); #1;
    check_eq("wr c1 mem_write", mem_write[0], 1);
    check_eq("wr c1 mem_addr", mem_addr[0], 32'h20);
    check_eq("wr c1 mem_wd", mem_wd[0], 32'h12345678);
    check_eq("wr c1 mem_read", mem_read[0], 0);
    next_cyc(); m0_req[0] = 1'b1; m0_addr[0] = 32'h20; #1;
    check_eq("wr c2 mem_write", mem_write[0], 0);
    check_eq("wr c2 m1_done", m1_done[0], 1);
    check_eq("wr c2 m0_ready", m0_ready[0], 1);
    next_cyc(); m0_req[0] = 1'b0; #1;
    check_eq("rb c1 mem_read", mem_read[0], 1);
    next_cyc(); #1;
    next_cyc(); #1;
    check_eq("rb m0_done", m0_done[0], 1);
    check_eq("rb m0_rdata", m0_rdata[0], 32'h12345678);

    // MEM_LAT=3: one clean read, then a read killed by reset mid-access.
    next_cyc(); m0_req[1] = 1'b1; m0_addr[1] = 32'h14; #1;
    check_eq("l3 c0 m0_ready", m0_ready[1], 1);
    next_cyc(); m0_req[1] = 1'b0; #1;
    for (int k = 0; k < 3; k++) begin
      next_cyc(); #1;
    end
    check_eq("l3 c4 m0_done", m0_done[1], 0);
    check_eq("l3 c4 mem_read", mem_read[1], 1);
    next_cyc(); m0_req[1] = 1'b1; m0_addr[1] = 32'h10; #1;
    check_eq("l3 c5 m0_done", m0_done[1], 1);
    check_eq("l3 c5 m0_rdata", m0_rdata[1], 32'hCAFEF00D);
    check_eq("l3 c5 m0_ready", m0_ready[1], 1);
    next_cyc(); m0_req[1] = 1'b0; #1;
    check_eq("l3 acc1 mem_read", mem_read[1], 1);
    next_cyc(); rst[1] = 1'b0; #1;
    check_eq("l3 acc2 mem_read", mem_read[1], 1);
    next_cyc(); rst[1] = 1'b1; #1;
    check_eq("l3 post-rst mem_read", mem_read[1], 0);
    check_eq("l3 post-rst m0_rdata", m0_rdata[1], 0);
    seen = m0_done[1];
    for (int k = 0; k < 6; k++) begin
      next_cyc(); #1;
      seen = seen | m0_done[1];
    end
    check_eq("l3 killed m0_done", seen, 0);
    next_cyc(); m1_req[1] = 1'b1; m1_addr[1] = 32'h18; #1;
    check_eq("l3 m1 c0 m1_ready", m1_ready[1], 1);
    next_cyc(); m1_req[1] = 1'b0; #1;
    for (int k = 0; k < 3; k++) begin
      next_cyc(); #1;
    end
    check_eq("l3 m1 c4 m1_done", m1_done[1], 0);
    next_cyc(); #1;
    check_eq("l3 m1 c5 m1_done", m1_done[1], 1);
    check_eq("l3 m1 c5 m1_rdata", m1_rdata[1], 32'h0BADF00D);

    // MEM_LAT=0: three back-to-back reads with req held.
    next_cyc(); m0_req[2] = 1'b1; m0_addr[2] = 32'h10; #1;
    check_eq("l0 c0 m0_ready", m0_ready[2], 1);
    next_cyc(); m0_addr[2] = 32'h14; #1;
    check_eq("l0 c1 mem_read", mem_read[2], 1);
    check_eq("l0 c1 m0_ready", m0_ready[2], 0);
    next_cyc(); #1;
    check_eq("l0 c2 m0_done", m0_done[2], 1);
    check_eq("l0 c2 m0_rdata", m0_rdata[2], 32'hDEADBEEF);
    check_eq("l0 c2 m0_ready", m0_ready[2], 1);
    next_cyc(); m0_addr[2] = 32'h18; #1;
    check_eq("l0 c3 m0_done", m0_done[2], 0);
    next_cyc(); #1;
    check_eq("l0 c4 m0_done", m0_done[2], 1);
    check_eq("l0 c4 m0_rdata", m0_rdata[2], 32'hCAFEF00D);
    check_eq("l0 c4 m0_ready", m0_ready[2], 1);
    next_cyc(); m0_req[2] = 1'b0; #1;
    next_cyc(); #1;
    check_eq("l0 c6 m0_done", m0_done[2], 1);
    check_eq("l0 c6 m0_rdata", m0_rdata[2], 32'h0BADF00D);
    check_eq("l0 c6 m0_ready", m0_ready[2], 0);

`ifdef DMEM_ARB_ALIGN_CHK_EN
    // Misaligned read: no strobe, done+err at cycle 2, rdata untouched.
    next_cyc(); m0_req[0] = 1'b1; m0_addr[0] = 32'h22; #1;
    check_eq("al c0 m0_ready", m0_ready[0], 1);
    next_cyc(); m0_req[0] = 1'b0; #1;
    check_eq("al c1 mem_read", mem_read[0], 0);
    check_eq("al c1 mem_write", mem_write[0], 0);
    next_cyc(); #1;
    check_eq("al c2 m0_done", m0_done[0], 1);
    check_eq("al c2 m0_err", m0_err[0], 1);
    check_eq("al c2 m0_rdata", m0_rdata[0], 32'h12345678);
    next_cyc(); #1;
    check_eq("al c3 m0_err", m0_err[0], 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port (dmem: combinational read, clocked write) between two requesters: port 0 (CPU load/store path) and port 1 (debug/loader DMA).
- Accepts one word transaction at a time, sequences the memory strobes, inserts MEM_LAT read wait cycles, and returns a one-cycle completion pulse with read data.
- Round-robin fairness between the two ports.

Parameters:
- ADDR_W, 32, byte address width
- DATA_W, 32, data word width
- MEM_LAT, 1, extra ACCESS cycles held before read data is sampled (0..15)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-low
- m0_req  in  1  port 0 request; addr/we/wdata must stay stable while req=1 and ready=0
- m0_we  in  1  1=write, 0=read
- m0_addr  in  ADDR_W  byte address
- m0_wdata  in  DATA_W  write data
- m0_ready  out  1  request accepted this cycle (combinational)
- m0_done  out  1  one-cycle completion pulse (registered)
- m0_rdata  out  DATA_W  read data; valid with done, held until the next port-0 read completes
- m1_*  same six signals for port 1
- mem_read  out  1  dmem read enable
- mem_write  out  1  dmem write enable
- mem_addr  out  ADDR_W  dmem address
- mem_wd  out  DATA_W  dmem write data
- mem_rd  in  DATA_W  dmem read data

Behaviour:
- Reset (rst=0 at a clk edge, any state):
  - state=IDLE, counter=0, last_grant=1, all done=0, rdata=0.
  - mem_read/mem_write low from the next cycle; any in-flight transaction is discarded with no done pulse.
- FSM states: IDLE, ACCESS.
- IDLE:
  - Grant selection:
    - Only one req high: grant that port.
    - Both high: grant the port != last_grant.
  - mX_ready=1 for the granted port, combinationally in the same cycle.
  - On accept: latch owner, we, addr, wdata; last_grant<=owner; counter<=MEM_LAT; go to ACCESS.
  - No req: stay in IDLE.
- ACCESS:
  - mem_addr=latched addr throughout.
  - Write:
    - mem_write=1 and mem_wd=latched wdata for the first ACCESS cycle only; ACCESS lasts exactly 1 cycle.
    - Then IDLE; done pulses in the following cycle.
  - Read:
    - mem_read=1 for every ACCESS cycle; counter decrements each cycle.
    - When counter==0: capture mem_rd into owner's rdata, go to IDLE; done pulses in the following cycle.
- Outside ACCESS: mem_read=mem_write=0, mem_addr=mem_wd=0.
- Latency, with accept at cycle 0:
  - Read: ACCESS cycles 1..1+MEM_LAT, done at cycle 2+MEM_LAT.
  - Write: mem_write at cycle 1, done at cycle 2.
- Overlap: the done cycle is an IDLE cycle, so a new accept may coincide with done.
  - Peak throughput: one read per 2+MEM_LAT cycles, one write per 2 cycles.
- ready is never asserted outside IDLE. Requests arriving during ACCESS wait; no request is lost while req is held.
- Requester may hold req high after ready for back-to-back transactions; each ready cycle is a distinct transaction.
- last_grant only updates on accept, so a lone requester never changes fairness for a later simultaneous pair beyond its own grant.

Optional Feature:
- Macro: DMEM_ARB_ALIGN_CHK_EN
- Defined:
  - Adds outputs m0_err/m1_err (1 bit, registered, pulse with done).
  - An accepted transaction with addr[1:0]!=0 performs no mem strobe and spends 1 ACCESS cycle; done+err pulse at cycle 2, rdata unchanged.
- Undefined:
  - No err ports; addr passed unmodified to dmem, which ignores [1:0].

Decomposition:
- Shared package dmem_arb_pkg holds:
  - state encoding (ST_IDLE, ST_ACCESS)
  - port id constants (PORT_CPU=0, PORT_DMA=1)
  - counter width constant LAT_W=4
- Sub-module rr_arbiter2: combinational 2-way round-robin picker (inputs req[1:0], last_grant, enable; outputs grant one-hot, grant_id). Used once in IDLE.

Test Plan:
- Single read, MEM_LAT=1, dmem[0x10]=0xDEADBEEF, m0 reads 0x10 -> m0_ready cycle 0, mem_read cycles 1-2, m0_done cycle 3 with m0_rdata=0xDEADBEEF, m1_done stays 0.
- Both ports request at the same cycle right after reset -> m0 granted first; m1 granted at m0's done cycle. Repeat the pair -> m0 then m1 again (alternation).
- m1 writes 0x12345678 to 0x20 -> mem_write high exactly 1 cycle (cycle 1), m1_done cycle 2. A following m0 read of 0x20 returns 0x12345678.
- MEM_LAT=3, m0 read; rst=0 asserted in the second ACCESS cycle -> next cycle mem_read=0, no m0_done ever, rdata=0. After release, an m1 read completes normally with done at cycle 5.
- MEM_LAT=0, m0_req held high for 3 reads -> ready at cycles 0, 2, 4; done at cycles 2, 4, 6 with correct data each.
- DMEM_ARB_ALIGN_CHK_EN defined, m0 read of 0x22 -> no mem strobe, m0_done and m0_err at cycle 2, m0_rdata unchanged.
